// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: load/store unit between EX and WB.
// Accepts one op per handshake. It issues a single outstanding valid/ready request
// to data memory, then aligns and extends the load response. The result is returned
// through a registered output that honours WB backpressure. A flush kills the pending
// op and any in-flight request.
module mem_lsu_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TAG_W   = 6,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [2:0]          in_funct3,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [RD_W-1:0]     in_rd,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                req_valid,
    input  logic                req_ready,
    output logic                req_we,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [DATA_W-1:0]   req_wdata,
    output logic [DATA_W/8-1:0] req_mask,
    input  logic                rsp_valid,
    input  logic                rsp_err,
    input  logic [DATA_W-1:0]   rsp_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RD_W-1:0]     out_rd,
    output logic [TAG_W-1:0]    out_tag,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_exc,
    output logic [3:0]          out_exc_code
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [3:0] EXC_ILLEGAL   = 4'd2;
    localparam logic [3:0] EXC_LD_MISAL  = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT  = 4'd5;
    localparam logic [3:0] EXC_ST_MISAL  = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT  = 4'd7;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    // Byte enables covering (1<<sz) lanes starting at lane off.
    function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        logic [NB-1:0] m;
        int o;
        m = '0;
        o = int'(off);
        for (int i = 0; i < NB; i++) begin
            if (i >= o && i < o + (1 << sz)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        return (int'(off) & ((1 << sz) - 1)) != 0;
    endfunction

    // Moves the addressed bytes to bit 0, then sign- or zero-extends them from the access width.
    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] data,
                                                       input logic [2:0] f3,
                                                       input logic [OFF_W-1:0] off);
        logic [DATA_W-1:0] s;
        logic sgn;
        int w;
        s = data >> {off, 3'b000};
        w = 8 << f3[1:0];
        if (w >= DATA_W) return s;
        sgn = ~f3[2] & s[w-1];
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= w) s[i] = sgn;
        end
        return s;
    endfunction

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [NB-1:0]       req_mask_q, req_mask_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                out_valid_q, out_valid_d;
    logic [RD_W-1:0]     out_rd_q, out_rd_d;
    logic [TAG_W-1:0]    out_tag_q, out_tag_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_exc_q, out_exc_d;
    logic [3:0]          out_exc_code_q, out_exc_code_d;

    logic                out_space;
    logic                accept;
    logic                illegal;
    logic [OFF_W-1:0]    acc_off;

    assign acc_off   = in_addr[OFF_W-1:0];
    assign out_space = !out_valid_q || out_ready;
    assign in_ready  = (state_q == S_IDLE) && !flush && out_space;
    assign accept    = in_valid && in_ready;

    assign req_valid    = (state_q == S_REQ);
    assign req_we       = we_q;
    assign req_addr     = req_addr_q;
    assign req_wdata    = req_wdata_q;
    assign req_mask     = req_mask_q;
    assign out_valid    = out_valid_q;
    assign out_rd       = out_rd_q;
    assign out_tag      = out_tag_q;
    assign out_data     = out_data_q;
    assign out_exc      = out_exc_q;
    assign out_exc_code = out_exc_code_q;

    // Decode of encodings that cannot be executed at this data width.
    always_comb begin
        illegal = 1'b0;
        if (in_op == OP_RSVD) illegal = 1'b1;
        if (DATA_W == 32 && in_funct3[1:0] == 2'd3) illegal = 1'b1;
        if (in_op == OP_LOAD && in_funct3 == 3'd7) illegal = 1'b1;
        if (in_op == OP_STORE && in_funct3[2]) illegal = 1'b1;
    end

    // Next-state logic for the request FSM, the latched op and the output register.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        we_d           = we_q;
        f3_d           = f3_q;
        off_d          = off_q;
        req_addr_d     = req_addr_q;
        req_wdata_d    = req_wdata_q;
        req_mask_d     = req_mask_q;
        rd_d           = rd_q;
        tag_d          = tag_q;
        out_valid_d    = out_valid_q && !out_ready;
        out_rd_d       = out_rd_q;
        out_tag_d      = out_tag_q;
        out_data_d     = out_data_q;
        out_exc_d      = out_exc_q;
        out_exc_code_d = out_exc_code_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_op == OP_NONE) begin
                        out_valid_d    = 1'b1;
                        out_rd_d       = in_rd;
                        out_tag_d      = in_tag;
                        out_data_d     = DATA_W'(in_addr);
                        out_exc_d      = 1'b0;
                        out_exc_code_d = 4'd0;
                    end else if (illegal || is_misaligned(in_funct3[1:0], acc_off)) begin
                        out_valid_d    = 1'b1;
                        out_rd_d       = in_rd;
                        out_tag_d      = in_tag;
                        out_data_d     = '0;
                        out_exc_d      = 1'b1;
                        if (illegal)               out_exc_code_d = EXC_ILLEGAL;
                        else if (in_op == OP_LOAD) out_exc_code_d = EXC_LD_MISAL;
                        else                       out_exc_code_d = EXC_ST_MISAL;
                    end else begin
                        state_d     = S_REQ;
                        we_d        = (in_op == OP_STORE);
                        f3_d        = in_funct3;
                        off_d       = acc_off;
                        req_addr_d  = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        req_wdata_d = in_wdata << {acc_off, 3'b000};
                        req_mask_d  = lane_mask(in_funct3[1:0], acc_off);
                        rd_d        = in_rd;
                        tag_d       = in_tag;
                    end
                end
            end
            S_REQ: begin
                if (req_ready) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (rsp_valid) begin
                    state_d        = S_IDLE;
                    out_valid_d    = 1'b1;
                    out_rd_d       = rd_q;
                    out_tag_d      = tag_q;
                    out_exc_d      = rsp_err;
                    out_exc_code_d = rsp_err ? (we_q ? EXC_ST_FAULT : EXC_LD_FAULT) : 4'd0;
                    out_data_d     = (rsp_err || we_q) ? '0 : load_extract(rsp_rdata, f3_q, off_q);
                end else if (TIMEOUT != 0 && timer_q == TMR_LAST) begin
                    state_d        = S_IDLE;
                    out_valid_d    = 1'b1;
                    out_rd_d       = rd_q;
                    out_tag_d      = tag_q;
                    out_exc_d      = 1'b1;
                    out_exc_code_d = we_q ? EXC_ST_FAULT : EXC_LD_FAULT;
                    out_data_d     = '0;
                end
            end
            S_DRAIN: begin
                if (rsp_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush overrides everything: a pending result is dropped and any issued request must drain.
        if (flush) begin
            out_valid_d = 1'b0;
            unique case (state_q)
                S_REQ:   state_d = req_ready ? S_DRAIN : S_IDLE;
                S_WAIT:  state_d = S_DRAIN;
                S_DRAIN: state_d = S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            we_q           <= 1'b0;
            f3_q           <= '0;
            off_q          <= '0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_mask_q     <= '0;
            rd_q           <= '0;
            tag_q          <= '0;
            out_valid_q    <= 1'b0;
            out_rd_q       <= '0;
            out_tag_q      <= '0;
            out_data_q     <= '0;
            out_exc_q      <= 1'b0;
            out_exc_code_q <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            we_q           <= we_d;
            f3_q           <= f3_d;
            off_q          <= off_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            req_mask_q     <= req_mask_d;
            rd_q           <= rd_d;
            tag_q          <= tag_d;
            out_valid_q    <= out_valid_d;
            out_rd_q       <= out_rd_d;
            out_tag_q      <= out_tag_d;
            out_data_q     <= out_data_d;
            out_exc_q      <= out_exc_d;
            out_exc_code_q <= out_exc_code_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage: a 32-bit instance (TIMEOUT=8) and a 64-bit instance.
module tb_mem_lsu_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;

    logic        in_valid, in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic [5:0]  in_tag;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_mask;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic [5:0]  out_tag;
    logic [31:0] out_data;
    logic        out_exc;
    logic [3:0]  out_exc_code;

    logic        d_in_valid, d_in_ready;
    logic [1:0]  d_in_op;
    logic [2:0]  d_in_funct3;
    logic [31:0] d_in_addr;
    logic [63:0] d_in_wdata;
    logic [4:0]  d_in_rd;
    logic [5:0]  d_in_tag;
    logic        d_req_valid, d_req_ready, d_req_we;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic [7:0]  d_req_mask;
    logic        d_rsp_valid, d_rsp_err;
    logic [63:0] d_rsp_rdata;
    logic        d_out_valid, d_out_ready;
    logic [4:0]  d_out_rd;
    logic [5:0]  d_out_tag;
    logic [63:0] d_out_data;
    logic        d_out_exc;
    logic [3:0]  d_out_exc_code;

    mem_lsu_stage #(.DATA_W(32), .ADDR_W(32), .TAG_W(6), .RD_W(5), .TIMEOUT(8)) u32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_tag(in_tag),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_tag(out_tag),
        .out_data(out_data), .out_exc(out_exc), .out_exc_code(out_exc_code)
    );

    mem_lsu_stage #(.DATA_W(64), .ADDR_W(32), .TAG_W(6), .RD_W(5), .TIMEOUT(8)) u64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_op(d_in_op), .in_funct3(d_in_funct3),
        .in_addr(d_in_addr), .in_wdata(d_in_wdata), .in_rd(d_in_rd), .in_tag(d_in_tag),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we), .req_addr(d_req_addr),
        .req_wdata(d_req_wdata), .req_mask(d_req_mask),
        .rsp_valid(d_rsp_valid), .rsp_err(d_rsp_err), .rsp_rdata(d_rsp_rdata),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_rd(d_out_rd), .out_tag(d_out_tag),
        .out_data(d_out_data), .out_exc(d_out_exc), .out_exc_code(d_out_exc_code)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [5:0] tag);
        in_valid  = 1'b1;
        in_op     = op;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wdata;
        in_rd     = rd;
        in_tag    = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_op = '0; in_funct3 = '0; in_addr = '0; in_wdata = '0; in_rd = '0; in_tag = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0; out_ready = 1'b1;
        d_in_valid = 1'b0; d_in_op = '0; d_in_funct3 = '0; d_in_addr = '0; d_in_wdata = '0;
        d_in_rd = '0; d_in_tag = '0; d_req_ready = 1'b0; d_rsp_valid = 1'b0; d_rsp_err = 1'b0;
        d_rsp_rdata = '0; d_out_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_req_mask", 64'(req_mask), 64'd0);
        chk("rst_exc_code", 64'(out_exc_code), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
        tick();

        // LB 0x1003: sign-extended byte from lane 3, nominal latency
        drive(2'd1, 3'd0, 32'h1003, 32'h0, 5'd5, 6'd1);
        #1 chk("lb_in_ready", 64'(in_ready), 64'd1);
        tick(); in_valid = 1'b0;
        chk("lb_req_valid_n1", 64'(req_valid), 64'd1);
        chk("lb_req_addr", 64'(req_addr), 64'h1000);
        chk("lb_req_mask", 64'(req_mask), 64'b1000);
        chk("lb_req_we", 64'(req_we), 64'd0);
        req_ready = 1'b1;
        tick(); req_ready = 1'b0;
        chk("lb_req_valid_n2", 64'(req_valid), 64'd0);
        chk("lb_out_valid_n2", 64'(out_valid), 64'd0);
        rsp_valid = 1'b1; rsp_rdata = 32'h80AABBCC;
        tick(); rsp_valid = 1'b0;
        chk("lb_out_valid_n3", 64'(out_valid), 64'd1);
        chk("lb_out_data", 64'(out_data), 64'hFFFFFF80);
        chk("lb_out_rd", 64'(out_rd), 64'd5);
        chk("lb_out_tag", 64'(out_tag), 64'd1);
        chk("lb_out_exc", 64'(out_exc), 64'd0);
        tick();
        chk("lb_out_drained", 64'(out_valid), 64'd0);

        // LHU 0x1002: zero-extended halfword from lanes 2..3
        drive(2'd1, 3'd5, 32'h1002, 32'h0, 5'd6, 6'd2);
        tick(); in_valid = 1'b0;
        chk("lhu_req_mask", 64'(req_mask), 64'b1100);
        req_ready = 1'b1;
        tick(); req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h80AABBCC;
        tick(); rsp_valid = 1'b0;
        chk("lhu_out_data", 64'(out_data), 64'h000080AA);
        tick();

        // SH 0x2002 with request backpressure, then output backpressure
        drive(2'd2, 3'd1, 32'h2002, 32'h0000BEEF, 5'd0, 6'd3);
        tick(); in_valid = 1'b0;
        chk("sh_req_we", 64'(req_we), 64'd1);
        chk("sh_req_mask", 64'(req_mask), 64'b1100);
        chk("sh_req_wdata", 64'(req_wdata), 64'hBEEF0000);
        chk("sh_req_addr", 64'(req_addr), 64'h2000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sh_hold_valid", 64'(req_valid), 64'd1);
            chk("sh_hold_wdata", 64'(req_wdata), 64'hBEEF0000);
            chk("sh_hold_mask", 64'(req_mask), 64'b1100);
            chk("sh_hold_addr", 64'(req_addr), 64'h2000);
        end
        req_ready = 1'b1;
        tick(); req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h12345678; out_ready = 1'b0;
        tick(); rsp_valid = 1'b0;
        chk("sh_out_valid", 64'(out_valid), 64'd1);
        chk("sh_out_exc", 64'(out_exc), 64'd0);
        chk("sh_out_data", 64'(out_data), 64'd0);
        chk("sh_bp_in_ready", 64'(in_ready), 64'd0);
        drive(2'd0, 3'd0, 32'h1234, 32'h0, 5'd3, 6'd4);
        tick();
        chk("bp_held_valid", 64'(out_valid), 64'd1);
        chk("bp_held_data", 64'(out_data), 64'd0);
        chk("bp_held_tag", 64'(out_tag), 64'd3);
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick(); in_valid = 1'b0;
        chk("none_out_valid", 64'(out_valid), 64'd1);
        chk("none_out_data", 64'(out_data), 64'h1234);
        chk("none_out_rd", 64'(out_rd), 64'd3);
        tick();
        chk("none_drained", 64'(out_valid), 64'd0);

        // Misaligned and illegal ops complete at N+1 with no request
        drive(2'd1, 3'd2, 32'h3002, 32'h0, 5'd1, 6'd5);
        tick(); in_valid = 1'b0;
        chk("lw_mis_req_valid", 64'(req_valid), 64'd0);
        chk("lw_mis_out_valid", 64'(out_valid), 64'd1);
        chk("lw_mis_exc", 64'(out_exc), 64'd1);
        chk("lw_mis_code", 64'(out_exc_code), 64'd4);
        chk("lw_mis_data", 64'(out_data), 64'd0);
        tick();
        chk("lw_mis_no_req", 64'(req_valid), 64'd0);
        drive(2'd1, 3'd3, 32'h3000, 32'h0, 5'd1, 6'd6);
        tick(); in_valid = 1'b0;
        chk("ld_f3_3_code", 64'(out_exc_code), 64'd2);
        chk("ld_f3_3_req", 64'(req_valid), 64'd0);
        drive(2'd2, 3'd2, 32'h3001, 32'h0, 5'd1, 6'd7);
        tick(); in_valid = 1'b0;
        chk("sw_mis_code", 64'(out_exc_code), 64'd6);
        drive(2'd3, 3'd0, 32'h3000, 32'h0, 5'd1, 6'd8);
        tick(); in_valid = 1'b0;
        chk("op3_code", 64'(out_exc_code), 64'd2);
        drive(2'd2, 3'd4, 32'h3000, 32'h0, 5'd1, 6'd9);
        tick(); in_valid = 1'b0;
        chk("st_f3_4_code", 64'(out_exc_code), 64'd2);
        chk("st_f3_4_req", 64'(req_valid), 64'd0);
        tick();

        // Timeout: fault exactly 8 cycles after entering WAIT
        drive(2'd1, 3'd2, 32'h5000, 32'h0, 5'd2, 6'd10);
        tick(); in_valid = 1'b0;
        req_ready = 1'b1;
        tick(); req_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("to_before", 64'(out_valid), 64'd0);
        tick();
        chk("to_out_valid", 64'(out_valid), 64'd1);
        chk("to_exc", 64'(out_exc), 64'd1);
        chk("to_code", 64'(out_exc_code), 64'd5);
        tick();

        // Load with rsp_err
        drive(2'd1, 3'd2, 32'h5100, 32'h0, 5'd2, 6'd11);
        tick(); in_valid = 1'b0;
        req_ready = 1'b1;
        tick(); req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = 32'hFFFFFFFF;
        tick(); rsp_valid = 1'b0; rsp_err = 1'b0;
        chk("err_code", 64'(out_exc_code), 64'd5);
        chk("err_data", 64'(out_data), 64'd0);
        tick();

        // Flush in WAIT, late response discarded, then a clean load
        drive(2'd1, 3'd2, 32'h6000, 32'h0, 5'd4, 6'd12);
        tick(); in_valid = 1'b0;
        req_ready = 1'b1;
        tick(); req_ready = 1'b0;
        flush = 1'b1;
        #1 chk("fl_in_ready", 64'(in_ready), 64'd0);
        tick(); flush = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_req_valid", 64'(req_valid), 64'd0);
        chk("fl_drain_in_ready", 64'(in_ready), 64'd0);
        tick(); tick();
        chk("fl_drain_hold", 64'(in_ready), 64'd0);
        rsp_valid = 1'b1; rsp_rdata = 32'hDEADBEEF;
        tick(); rsp_valid = 1'b0;
        chk("fl_discard_valid", 64'(out_valid), 64'd0);
        chk("fl_idle_in_ready", 64'(in_ready), 64'd1);
        drive(2'd1, 3'd2, 32'h7000, 32'h0, 5'd7, 6'd9);
        tick(); in_valid = 1'b0;
        req_ready = 1'b1;
        tick(); req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h12345678;
        tick(); rsp_valid = 1'b0;
        chk("post_fl_valid", 64'(out_valid), 64'd1);
        chk("post_fl_data", 64'(out_data), 64'h12345678);
        chk("post_fl_rd", 64'(out_rd), 64'd7);
        chk("post_fl_tag", 64'(out_tag), 64'd9);
        tick();

        // 64-bit instance: LWU and LW at offset 4
        d_in_valid = 1'b1; d_in_op = 2'd1; d_in_funct3 = 3'd6; d_in_addr = 32'h4004; d_in_rd = 5'd8; d_in_tag = 6'd20;
        tick(); d_in_valid = 1'b0;
        chk("d_lwu_mask", 64'(d_req_mask), 64'hF0);
        chk("d_lwu_addr", 64'(d_req_addr), 64'h4000);
        d_req_ready = 1'b1;
        tick(); d_req_ready = 1'b0;
        d_rsp_valid = 1'b1; d_rsp_rdata = 64'hF0000001_00000000;
        tick(); d_rsp_valid = 1'b0;
        chk("d_lwu_valid", 64'(d_out_valid), 64'd1);
        chk("d_lwu_data", d_out_data, 64'h00000000_F0000001);
        tick();
        d_in_valid = 1'b1; d_in_funct3 = 3'd2;
        tick(); d_in_valid = 1'b0;
        d_req_ready = 1'b1;
        tick(); d_req_ready = 1'b0;
        d_rsp_valid = 1'b1;
        tick(); d_rsp_valid = 1'b0;
        chk("d_lw_data", d_out_data, 64'hFFFFFFFF_F0000001);
        tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
